// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU-control decode with an iterative multiplier sequencer
// Ports:
//   Clk, Rst      rising-edge clock, async active-high reset
//   Flush         abandon any in-flight op, no OutValid
//   InValid       decode request valid; InReady high only while IDLE
//   ALUOp         00 R-type, 01 I-type, 10 jump, 11 reserved
//   Funct, IOp    R-type funct / I-type or jump opcode
//   OpA, OpB      multiplicand / multiplier for MUL
//   OutValid      one-cycle result pulse
//   ALUControl    decoded code (zero-extended), held between pulses
//   Product       low DATA_W bits of OpA*OpB on MUL, 0 for other ops
//   Illegal       unlisted encoding
module alu_ctrl_seq #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 8,
    parameter int CTRL_W = 6
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Funct,
    input  logic [5:0]        IOp,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    output logic              OutValid,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [DATA_W-1:0] Product,
    output logic              Illegal
);
    localparam int N  = DATA_W / STEP_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] MUL   = 1'b1;
    localparam logic [5:0] NOP   = 6'b111111;
    localparam logic [5:0] F_MUL = 6'b011000;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d, ill_q, ill_d;
    logic [5:0]        dec_ctrl;
    logic              dec_ill, is_mul, idle, accept, last;
    logic [DATA_W-1:0] step_a, step_b, acc_next;
    logic [CW-1:0]     step_cnt;

    always_comb begin
        dec_ctrl = NOP;
        dec_ill  = 1'b0;
        case (ALUOp)
            2'b00: case (Funct)
                6'b100000, 6'b100010, 6'b011000, 6'b100100, 6'b100101, 6'b100111,
                6'b100110, 6'b000000, 6'b000010, 6'b101010, 6'b001000: dec_ctrl = Funct;
                default: dec_ill = 1'b1;
            endcase
            2'b01: case (IOp)
                6'b101011, 6'b100011, 6'b001000, 6'b101000,
                6'b100000, 6'b101001, 6'b100001: dec_ctrl = 6'b100000;
                6'b001100: dec_ctrl = 6'b100100;
                6'b001101: dec_ctrl = 6'b100101;
                6'b001110: dec_ctrl = 6'b100110;
                6'b001010: dec_ctrl = 6'b101010;
                6'b000001, 6'b000100, 6'b000101, 6'b000111, 6'b000110: dec_ctrl = IOp;
                default: dec_ill = 1'b1;
            endcase
            2'b10: dec_ill = !(IOp == 6'b000010 || IOp == 6'b000011);
            default: dec_ill = 1'b1;
        endcase
    end

    assign is_mul  = (ALUOp == 2'b00) && (Funct == F_MUL);
    assign idle    = (state_q == IDLE);
    assign InReady = idle;
    assign accept  = idle && InValid && !Flush;

    // The accept cycle performs step 0 from the live operands, so the
    // MUL state only spends N-1 cycles and OutValid lands at t+N.
    assign step_a   = idle ? OpA : a_q;
    assign step_b   = idle ? OpB : b_q;
    assign step_cnt = idle ? '0 : cnt_q;
    assign acc_next = (idle ? '0 : acc_q)
                    + ((step_a * DATA_W'(step_b[STEP_W-1:0])) << (32'(step_cnt) * 32'(STEP_W)));
    assign last     = (step_cnt == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        ctrl_d  = ctrl_q;
        prod_d  = prod_q;
        ill_d   = ill_q;
        if (Flush) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept && !is_mul) begin
            valid_d = 1'b1;
            ctrl_d  = CTRL_W'(dec_ctrl);
            prod_d  = '0;
            ill_d   = dec_ill;
        end else if (accept || !idle) begin
            if (last) begin
                state_d = IDLE;
                valid_d = 1'b1;
                ctrl_d  = CTRL_W'(F_MUL);
                prod_d  = acc_next;
                ill_d   = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = MUL;
                a_d     = step_a;
                b_d     = step_b >> STEP_W;
                acc_d   = acc_next;
                cnt_d   = step_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_W'(NOP);
            prod_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            prod_q  <= prod_d;
            ill_q   <= ill_d;
        end
    end

    assign OutValid   = valid_q;
    assign ALUControl = ctrl_q;
    assign Product    = prod_q;
    assign Illegal    = ill_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed bench with a cycle-level reference model for alu_ctrl_seq
module tb_alu_ctrl_seq;
    localparam int N = 4;

    logic        Clk, Rst, Flush, InValid, InReady, OutValid, Illegal;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct, IOp, ALUControl;
    logic [31:0] OpA, OpB, Product;

    int n_cmp = 0;
    int n_bad = 0;

    alu_ctrl_seq dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .ALUOp(ALUOp), .Funct(Funct), .IOp(IOp), .OpA(OpA), .OpB(OpB),
        .OutValid(OutValid), .ALUControl(ALUControl), .Product(Product), .Illegal(Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f, input logic [5:0] i,
                                    output logic [5:0] c, output logic il);
        c  = 6'h3f;
        il = 1'b1;
        if (op == 2'b00 && f inside {6'h20, 6'h22, 6'h18, 6'h24, 6'h25, 6'h27, 6'h26, 6'h00, 6'h02, 6'h2a, 6'h08}) begin
            c = f; il = 1'b0;
        end else if (op == 2'b01) begin
            il = 1'b0;
            if (i inside {6'h2b, 6'h23, 6'h08, 6'h28, 6'h20, 6'h29, 6'h21}) c = 6'h20;
            else if (i == 6'h0c) c = 6'h24;
            else if (i == 6'h0d) c = 6'h25;
            else if (i == 6'h0e) c = 6'h26;
            else if (i == 6'h0a) c = 6'h2a;
            else if (i inside {6'h01, 6'h04, 6'h05, 6'h07, 6'h06}) c = i;
            else il = 1'b1;
        end else if (op == 2'b10 && (i == 6'h02 || i == 6'h03)) il = 1'b0;
    endfunction

    logic [5:0]  r_ctrl;
    logic        r_ill;
    always_comb ref_dec(ALUOp, Funct, IOp, r_ctrl, r_ill);

    // m_rem counts the cycles still to wait for a pending product.
    int          m_rem;
    logic        m_valid, m_ill;
    logic [5:0]  m_ctrl;
    logic [31:0] m_prod, m_pend;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_rem <= 0; m_valid <= 1'b0; m_ctrl <= 6'h3f; m_prod <= '0; m_ill <= 1'b0; m_pend <= '0;
        end else begin
            m_valid <= 1'b0;
            if (Flush) m_rem <= 0;
            else if (m_rem > 0) begin
                if (m_rem == 1) begin
                    m_valid <= 1'b1; m_ctrl <= 6'h18; m_prod <= m_pend; m_ill <= 1'b0;
                end
                m_rem <= m_rem - 1;
            end else if (InValid) begin
                if (ALUOp == 2'b00 && Funct == 6'h18) begin
                    m_rem  <= N - 1;
                    m_pend <= OpA * OpB;
                end else begin
                    m_valid <= 1'b1; m_ctrl <= r_ctrl; m_prod <= '0; m_ill <= r_ill;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (!Rst) begin
            chk("m_valid", OutValid, m_valid);
            chk("m_ready", InReady, m_rem == 0);
            chk("m_ctrl", ALUControl, m_ctrl);
            chk("m_prod", Product, m_prod);
            chk("m_ill", Illegal, m_ill);
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [5:0] f, input logic [5:0] i,
                       input logic [31:0] a, input logic [31:0] b);
        InValid = 1'b1; ALUOp = op; Funct = f; IOp = i; OpA = a; OpB = b;
    endtask

    initial begin
        Rst = 1'b1; Flush = 1'b0; InValid = 1'b0; ALUOp = '0; Funct = '0; IOp = '0; OpA = '0; OpB = '0;
        step(); step();
        Rst = 1'b0;
        step();
        chk("rst_valid", OutValid, 0);
        chk("rst_ready", InReady, 1);
        chk("rst_ctrl", ALUControl, 6'h3f);
        chk("rst_prod", Product, 0);

        req(2'b00, 6'b100010, 6'h00, 32'd0, 32'd0); step(); InValid = 1'b0;
        chk("sub_valid", OutValid, 1);
        chk("sub_ctrl", ALUControl, 6'b100010);
        chk("sub_ill", Illegal, 0);
        step();
        chk("sub_pulse", OutValid, 0);
        chk("sub_hold", ALUControl, 6'b100010);

        req(2'b01, 6'h00, 6'b100011, 0, 0); step();
        chk("lw_ctrl", ALUControl, 6'b100000);
        IOp = 6'b001101; step();
        chk("ori_ctrl", ALUControl, 6'b100101);
        IOp = 6'b000110; step(); InValid = 1'b0;
        chk("blez_ctrl", ALUControl, 6'b000110);
        chk("blez_valid", OutValid, 1);

        req(2'b00, 6'b011000, 6'h00, 32'hFFFF_FFFF, 32'd3); step(); InValid = 1'b0;
        chk("mul_ready1", InReady, 0);
        chk("mul_novalid", OutValid, 0);
        req(2'b00, 6'b100000, 6'h00, 0, 0); step(); InValid = 1'b0;
        chk("mul_ready2", InReady, 0);
        chk("mul_ignored", OutValid, 0);
        step();
        chk("mul_ready3", InReady, 0);
        step();
        chk("mul_valid", OutValid, 1);
        chk("mul_prod", Product, 32'hFFFF_FFFD);
        chk("mul_ctrl", ALUControl, 6'b011000);
        chk("mul_ready4", InReady, 1);

        req(2'b00, 6'b011000, 6'h00, 32'd7, 32'd6); step(); InValid = 1'b0;
        step();
        Flush = 1'b1; step(); Flush = 1'b0;
        chk("flush_valid", OutValid, 0);
        chk("flush_ready", InReady, 1);
        req(2'b00, 6'b100000, 6'h00, 0, 0); step(); InValid = 1'b0;
        chk("add_valid", OutValid, 1);
        chk("add_ctrl", ALUControl, 6'b100000);
        chk("add_prod", Product, 0);

        req(2'b00, 6'b100100, 6'h00, 0, 0); Flush = 1'b1; step(); InValid = 1'b0; Flush = 1'b0;
        chk("flush_idle", OutValid, 0);

        req(2'b11, 6'h20, 6'h00, 0, 0); step();
        chk("rsv_ill", Illegal, 1);
        chk("rsv_ctrl", ALUControl, 6'h3f);
        req(2'b10, 6'h00, 6'b000011, 0, 0); step();
        chk("jal_ill", Illegal, 0);
        chk("jal_ctrl", ALUControl, 6'h3f);
        req(2'b00, 6'b111111, 6'h00, 0, 0); step();
        chk("badf_ill", Illegal, 1);
        req(2'b01, 6'h00, 6'b001010, 0, 0); step(); InValid = 1'b0;
        chk("slti_ctrl", ALUControl, 6'b101010);

        req(2'b00, 6'b011000, 6'h00, 32'h0001_0001, 32'h0001_0001); step(); InValid = 1'b0;
        repeat (N - 1) step();
        chk("mul2_prod", Product, 32'h0002_0001);
        req(2'b00, 6'b011000, 6'h00, 32'h1234_5678, 32'h9ABC_DEF0); step(); InValid = 1'b0;
        repeat (N - 1) step();
        chk("mul3_valid", OutValid, 1);

        req(2'b00, 6'b011000, 6'h00, 32'd9, 32'd9); step(); InValid = 1'b0;
        step();
        Rst = 1'b1; #1;
        chk("arst_valid", OutValid, 0);
        chk("arst_ready", InReady, 1);
        chk("arst_ctrl", ALUControl, 6'h3f);
        chk("arst_prod", Product, 0);
        chk("arst_ill", Illegal, 0);
        step();
        Rst = 1'b0;
        repeat (N + 1) step();
        chk("arst_after", OutValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
